// File: rtl/kianv_dmem_pkg.sv
// Shared types and constants for the KianV M-stage data-memory responder.
package kianv_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } DmemState_t;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/kianv_dmem_watchdog.sv
// Saturating wait-state counter; expired flags that TIMEOUT_CYCLES waits have elapsed.
module kianv_dmem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam bit ARMED = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] count_reg;

  // Stops at LIMIT; with the watchdog disabled LIMIT is 0 so the count never moves.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = ARMED && (count_reg == LIMIT);

endmodule

// File: rtl/kianv_dmem_responder.sv
// M-stage data-memory responder: stalls the core, runs one valid/ready
// transaction to memory per access and returns load data on ReadDataM.
module kianv_dmem_responder
  import kianv_dmem_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReadMemM,
  input  logic [3:0]  WriteMaskM,
  input  logic [31:0] AluResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        halt,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err,
  output logic        protocol_err
);

  DmemState_t state_reg, state_next;

  logic req;
  logic conflict;
  logic accept;
  logic finish_ok;
  logic finish_timeout;
  logic wd_count;
  logic wd_expired;
  logic is_read;
  logic unused_addr_bits;

  assign req      = ReadMemM | (|WriteMaskM);
  assign conflict = ReadMemM & (|WriteMaskM);
  assign is_read  = (mem_wstrb == 4'b0000);
  assign unused_addr_bits = ^AluResultM[1:0];

  kianv_dmem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (wd_count),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // mem_ready is checked before expiry so a late but valid response still wins.
  always_comb begin
    state_next     = state_reg;
    halt           = 1'b0;
    accept         = 1'b0;
    finish_ok      = 1'b0;
    finish_timeout = 1'b0;
    wd_count       = 1'b0;
    case (state_reg)
      IDLE: begin
        halt = req;
        if (req) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        halt = 1'b1;
        if (mem_ready) begin
          finish_ok  = 1'b1;
          state_next = DONE;
        end else if (wd_expired) begin
          finish_timeout = 1'b1;
          state_next     = DONE;
        end else begin
          wd_count = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      ReadDataM    <= '0;
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (accept) begin
        mem_valid <= 1'b1;
        mem_addr  <= {AluResultM[31:2], 2'b00};
        mem_wdata <= WriteDataM;
        mem_wstrb <= WriteMaskM;
        // The store goes out; the load half of a conflicting request gets the error word.
        if (conflict) begin
          protocol_err <= 1'b1;
          ReadDataM    <= ERR_RDATA;
        end
      end
      if (finish_ok) begin
        mem_valid <= 1'b0;
        if (is_read) begin
          ReadDataM <= mem_rdata;
        end
      end
      if (finish_timeout) begin
        mem_valid   <= 1'b0;
        timeout_err <= 1'b1;
        if (is_read) begin
          ReadDataM <= ERR_RDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_kianv_dmem_responder.sv
// Bench for kianv_dmem_responder: directed scenarios followed by random accesses,
// each checked against a transaction-level model of the expected outcome.
module tb_kianv_dmem_responder;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReadMemM;
  logic [3:0]  WriteMaskM;
  logic [31:0] AluResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        halt;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        timeout_err;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rdata;
  logic        exp_to;
  logic        exp_pe;

  kianv_dmem_responder #(
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (ERR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ReadMemM    (ReadMemM),
    .WriteMaskM  (WriteMaskM),
    .AluResultM  (AluResultM),
    .WriteDataM  (WriteDataM),
    .ReadDataM   (ReadDataM),
    .halt        (halt),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .timeout_err (timeout_err),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".mem_valid"},    32'(mem_valid),    32'd0);
    check({tag, ".mem_addr"},     mem_addr,          32'd0);
    check({tag, ".mem_wdata"},    mem_wdata,         32'd0);
    check({tag, ".mem_wstrb"},    32'(mem_wstrb),    32'd0);
    check({tag, ".ReadDataM"},    ReadDataM,         32'd0);
    check({tag, ".timeout_err"},  32'(timeout_err),  32'd0);
    check({tag, ".protocol_err"}, 32'(protocol_err), 32'd0);
    check({tag, ".halt"},         32'(halt),         32'd0);
  endtask

  // One core access; memory answers on the (w+1)-th cycle of mem_valid.
  task automatic do_access(input string tag, input logic rd, input logic [3:0] mask,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int w);
    logic       conflict;
    logic       timed;
    int         eff;
    int         halt_cnt;
    int         vcnt;
    logic       finished;
    logic [3:0] exp_strb;
    conflict = rd && (mask != 4'd0);
    timed    = (w > TO);
    eff      = timed ? TO : w;
    exp_strb = mask;
    halt_cnt = 0;
    vcnt     = 0;
    finished = 1'b0;
    @(negedge clk);
    ReadMemM   = rd;
    WriteMaskM = mask;
    AluResultM = addr;
    WriteDataM = wdata;
    mem_ready  = 1'b0;
    for (int c = 0; c < TO + w + 8 && !finished; c++) begin
      #1;
      if (!halt) begin
        finished = 1'b1;
      end else begin
        halt_cnt++;
        if (mem_valid) begin
          vcnt++;
          check({tag, ".mem_addr"},  mem_addr,        {addr[31:2], 2'b00});
          check({tag, ".mem_wstrb"}, 32'(mem_wstrb),  32'(exp_strb));
          check({tag, ".mem_wdata"}, mem_wdata,       wdata);
          mem_ready = (vcnt == w + 1);
          mem_rdata = mem_ready ? rdata : $urandom;
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
          mem_rdata = $urandom;
        end
        @(negedge clk);
      end
    end
    if (conflict)  exp_rdata = ERR;
    else if (rd)   exp_rdata = timed ? ERR : rdata;
    exp_to = exp_to | timed;
    exp_pe = exp_pe | conflict;
    check({tag, ".completed"},    32'(finished),     32'd1);
    check({tag, ".halt_cycles"},  32'(halt_cnt),     32'(eff + 2));
    check({tag, ".valid_cycles"}, 32'(vcnt),         32'(eff + 1));
    check({tag, ".done_valid"},   32'(mem_valid),    32'd0);
    check({tag, ".ReadDataM"},    ReadDataM,         exp_rdata);
    check({tag, ".timeout_err"},  32'(timeout_err),  32'(exp_to));
    check({tag, ".protocol_err"}, 32'(protocol_err), 32'(exp_pe));
    $display("txn %s rd=%0b mask=%h addr=%h waits=%0d halt_cycles=%0d rdata_out=%h",
             tag, rd, mask, addr, w, halt_cnt, ReadDataM);
  endtask

  task automatic idle_gap(input string tag);
    @(negedge clk);
    ReadMemM   = 1'b0;
    WriteMaskM = 4'd0;
    mem_ready  = 1'($urandom_range(0, 1));
    #1;
    check({tag, ".gap_halt"}, 32'(halt), 32'd0);
    @(negedge clk);
    check({tag, ".gap_valid"}, 32'(mem_valid), 32'd0);
  endtask

  initial begin
    logic       rd;
    logic [3:0] mask;
    int         kind;

    reset      = 1'b1;
    ReadMemM   = 1'b0;
    WriteMaskM = 4'd0;
    AluResultM = 32'd0;
    WriteDataM = 32'd0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'd0;
    exp_rdata  = 32'd0;
    exp_to     = 1'b0;
    exp_pe     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("reset");

    do_access("load_zero_wait", 1'b1, 4'b0000, 32'h0000_1006, 32'h1111_2222, 32'hCAFE_F00D, 0);
    idle_gap("load_zero_wait");
    do_access("store_3wait", 1'b0, 4'b0011, 32'h0000_0020, 32'h0000_BEEF, 32'h5555_AAAA, 3);
    do_access("timeout", 1'b1, 4'b0000, 32'h0000_0100, 32'h0, 32'h7777_7777, 9);
    idle_gap("timeout");
    do_access("store_after_to", 1'b0, 4'b1000, 32'h0000_0104, 32'hAB00_0000, 32'h0, 2);
    do_access("race", 1'b1, 4'b0000, 32'h0000_0200, 32'h0, 32'h1234_5678, TO);
    do_access("conflict", 1'b1, 4'b1111, 32'h0000_0300, 32'hFEED_FACE, 32'h9999_9999, 1);
    idle_gap("conflict");

    // Reset during WAIT abandons the access and restores every output.
    @(negedge clk);
    ReadMemM   = 1'b1;
    AluResultM = 32'h0000_0400;
    mem_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wait.valid_before", 32'(mem_valid), 32'd1);
    reset    = 1'b1;
    ReadMemM = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("rst_wait");
    exp_rdata = 32'd0;
    exp_to    = 1'b0;
    exp_pe    = 1'b0;
    $display("txn rst_wait reset applied during WAIT");
    do_access("after_reset", 1'b1, 4'b0000, 32'h0000_0408, 32'h0, 32'h0BAD_CAFE, 1);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      rd   = (kind <= 1) || (kind == 4);
      mask = (kind >= 2) ? 4'($urandom_range(1, 15)) : 4'd0;
      do_access($sformatf("rand%0d", i), rd, mask, $urandom, $urandom, $urandom,
                $urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1) idle_gap($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
